// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - default parameters and request record for the write-back arbiter
package regfile_wb_pkg;

  localparam int NUM_REQ_DEF    = 3;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int STAT_WIDTH_DEF = 16;

  // Sized to the defaults; narrower instances zero-extend into it.
  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - first set request at or after start, wrapping; one-hot grant plus index
module rr_priority_picker #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int  c;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < N; i++) begin
      c = int'(start) + i;
      if (c >= N) c = c - N;
      if (!found && req[IDX_W'(c)]) begin
        found              = 1'b1;
        grant[IDX_W'(c)]   = 1'b1;
        idx                = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter; WB_ARB_RR_EN selects round-robin over fixed priority
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int STAT_WIDTH = STAT_WIDTH_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_arst_n,
  input  logic                          i_stall,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_write_en_3,
  output logic [ADDR_WIDTH-1:0]         o_addr_3,
  output logic [DATA_WIDTH-1:0]         o_write_data_3,
  output logic [STAT_WIDTH-1:0]         o_conflict_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  wb_req_t              req [NUM_REQ];
  wb_req_t              sel;
  wb_req_t              wb_q;
  logic                 wb_en_q;
  logic [NUM_REQ-1:0]   req_mask;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     start_ptr;
  logic                 xfer;
  logic                 conflict;
  logic [STAT_WIDTH-1:0] conflict_cnt_q;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req[k].addr = ADDR_WIDTH_DEF'(i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH]);
    assign req[k].data = DATA_WIDTH_DEF'(i_req_data[k*DATA_WIDTH +: DATA_WIDTH]);
  end

  assign req_mask = i_stall ? '0 : i_req_valid;

  rr_priority_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req_mask),
    .start (start_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign o_req_ready = grant;
  assign xfer        = |grant;
  assign sel         = req[grant_idx];
  // Two or more bits set: clearing the lowest set bit leaves something behind.
  assign conflict    = !i_stall && ((i_req_valid & (i_req_valid - 1'b1)) != '0);

`ifdef WB_ARB_RR_EN
  logic [IDX_W-1:0] rr_ptr_q;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      rr_ptr_q <= '0;
    end else if (xfer) begin
      rr_ptr_q <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign start_ptr = rr_ptr_q;
`else
  assign start_ptr = '0;
`endif

  // x0 writes finish the handshake but leave the write port and its last value alone.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wb_en_q <= 1'b0;
      wb_q    <= '0;
    end else begin
      wb_en_q <= 1'b0;
      if (xfer && (sel.addr != '0)) begin
        wb_en_q <= 1'b1;
        wb_q    <= sel;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      conflict_cnt_q <= '0;
    end else if (conflict && (conflict_cnt_q != '1)) begin
      conflict_cnt_q <= conflict_cnt_q + 1'b1;
    end
  end

  assign o_write_en_3   = wb_en_q;
  assign o_addr_3       = wb_q.addr[ADDR_WIDTH-1:0];
  assign o_write_data_3 = wb_q.data[DATA_WIDTH-1:0];
  assign o_conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed checks of the write-back arbiter, either build of WB_ARB_RR_EN
module tb_regfile_wb_arbiter;

  logic         i_clk = 1'b0;
  logic         i_arst_n;
  logic         i_stall;
  logic [2:0]   i_req_valid;
  logic [14:0]  i_req_addr;
  logic [191:0] i_req_data;
  logic [2:0]   o_req_ready, ready2;
  logic         o_write_en_3, en2;
  logic [4:0]   o_addr_3, addr2;
  logic [63:0]  o_write_data_3, data2;
  logic [15:0]  o_conflict_cnt;
  logic [1:0]   cnt2;

  logic [4:0]   a [3];
  logic [63:0]  d [3];
  logic [2:0]   exp_grant [4];
  logic [2:0]   exp_release;
  int           checks = 0;
  int           errors = 0;

  assign i_req_addr = {a[2], a[1], a[0]};
  assign i_req_data = {d[2], d[1], d[0]};

  always #5 i_clk = ~i_clk;

  regfile_wb_arbiter dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_stall(i_stall),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .o_write_en_3(o_write_en_3), .o_addr_3(o_addr_3),
    .o_write_data_3(o_write_data_3), .o_conflict_cnt(o_conflict_cnt)
  );

  regfile_wb_arbiter #(.STAT_WIDTH(2)) dut_sat (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_stall(i_stall),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_req_ready(ready2), .o_write_en_3(en2), .o_addr_3(addr2),
    .o_write_data_3(data2), .o_conflict_cnt(cnt2)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef WB_ARB_RR_EN
    exp_grant[0] = 3'b001; exp_grant[1] = 3'b010; exp_grant[2] = 3'b100; exp_grant[3] = 3'b001;
    exp_release  = 3'b010;
`else
    exp_grant[0] = 3'b001; exp_grant[1] = 3'b001; exp_grant[2] = 3'b001; exp_grant[3] = 3'b001;
    exp_release  = 3'b001;
`endif
    i_arst_n = 1'b0; i_stall = 1'b0; i_req_valid = '0;
    for (int k = 0; k < 3; k++) begin a[k] = '0; d[k] = '0; end
    tick(); tick();
    check("rst_en", o_write_en_3, 0);
    check("rst_addr", o_addr_3, 0);
    check("rst_data", o_write_data_3, 0);
    check("rst_cnt", o_conflict_cnt, 0);
    check("rst_ready", o_req_ready, 0);
    i_arst_n = 1'b1;

    // Reset lands between acceptance and the register-file edge.
    a[0] = 5'd5; d[0] = 64'hAA; i_req_valid = 3'b001;
    #1 check("t1_ready", o_req_ready, 3'b001);
    tick();
    check("t1_en_pre", o_write_en_3, 1);
    check("t1_addr_pre", o_addr_3, 5);
    i_arst_n = 1'b0; i_req_valid = '0;
    #1 check("t1_en_rst", o_write_en_3, 0);
    check("t1_addr_rst", o_addr_3, 0);
    check("t1_data_rst", o_write_data_3, 0);
    check("t1_cnt_rst", o_conflict_cnt, 0);
    tick();
    check("t1_en_hold", o_write_en_3, 0);
    i_arst_n = 1'b1;

    // Contention: all three valid for four cycles.
    a[0] = 5'd1; d[0] = 64'h10;
    a[1] = 5'd2; d[1] = 64'h20;
    a[2] = 5'd3; d[2] = 64'h30;
    i_req_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #1 check("t3_ready", o_req_ready, exp_grant[i]);
      tick();
      check("t3_en", o_write_en_3, 1);
      check("t3_addr", o_addr_3, (exp_grant[i] == 3'b001) ? 1 : (exp_grant[i] == 3'b010) ? 2 : 3);
      check("t3_data", o_write_data_3, (exp_grant[i] == 3'b001) ? 64'h10 :
                                       (exp_grant[i] == 3'b010) ? 64'h20 : 64'h30);
    end
    check("t3_cnt", o_conflict_cnt, 4);
    check("t6_sat_a", cnt2, 3);

    // Stall two cycles, then release.
    i_stall = 1'b1;
    #1 check("t5_ready0", o_req_ready, 0);
    tick();
    check("t5_en0", o_write_en_3, 0);
    check("t5_cnt0", o_conflict_cnt, 4);
    #1 check("t5_ready1", o_req_ready, 0);
    tick();
    check("t5_en1", o_write_en_3, 0);
    check("t5_cnt1", o_conflict_cnt, 4);
    i_stall = 1'b0;
    #1 check("t5_release", o_req_ready, exp_release);
    tick();
    check("t5_en_rel", o_write_en_3, 1);
    check("t5_addr_rel", o_addr_3, (exp_release == 3'b010) ? 2 : 1);
    check("t5_cnt_rel", o_conflict_cnt, 5);
    check("t6_sat_b", cnt2, 3);
    i_req_valid = '0;
    tick();
    check("idle_en", o_write_en_3, 0);

    // Single requester.
    a[1] = 5'd7; d[1] = 64'h1234; i_req_valid = 3'b010;
    #1 check("t2_ready", o_req_ready, 3'b010);
    tick();
    check("t2_en", o_write_en_3, 1);
    check("t2_addr", o_addr_3, 7);
    check("t2_data", o_write_data_3, 64'h1234);
    i_req_valid = '0;
    tick();
    check("t2_en_off", o_write_en_3, 0);
    check("t2_addr_hold", o_addr_3, 7);
    check("t2_data_hold", o_write_data_3, 64'h1234);
    check("t2_cnt", o_conflict_cnt, 5);

    // Write to x0 is accepted but absorbed.
    a[2] = 5'd0; d[2] = 64'hFF; i_req_valid = 3'b100;
    #1 check("t4_ready", o_req_ready, 3'b100);
    tick();
    check("t4_en", o_write_en_3, 0);
    check("t4_addr", o_addr_3, 7);
    check("t4_data", o_write_data_3, 64'h1234);
    i_req_valid = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
